// File: rtl/spi_mosi_if.sv
// rtl/spi_mosi_if.sv - byte-source / SPI-pin signal bundle for the MOSI transmit path
interface spi_mosi_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  spi_cs;
   logic [DATA_WIDTH-1:0] spi_mosi_in;
   logic                  control_clk;
   logic                  spi_mosi_out;

   // Drives chip select and the parallel byte, observes the serial pins
   modport master (
      output spi_cs,
      output spi_mosi_in,
      input  control_clk,
      input  spi_mosi_out
   );

   // The transmitter itself
   modport slave (
      input  spi_cs,
      input  spi_mosi_in,
      output control_clk,
      output spi_mosi_out
   );
endinterface

// File: rtl/spi_mosi.sv
// rtl/spi_mosi.sv - SPI master transmit path, serialises a byte MSB first onto MOSI
module spi_mosi #(
   parameter int DATA_WIDTH = 8
) (
   input  logic     spi_clk,
   input  logic     n_reset,
   spi_mosi_if.slave bus
);
   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT_LO,
      SHIFT_HI,
      GAP
   } state_t;

   state_t                state, state_nxt;
   logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
   logic [CW-1:0]         bit_cnt, bit_cnt_nxt;

   // State, shift register and bit counter; n_reset is active-high and wins over everything
   always_ff @(posedge spi_clk) begin
      if (n_reset) begin
         state   <= IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
      end else begin
         state   <= state_nxt;
         shreg   <= shreg_nxt;
         bit_cnt <= bit_cnt_nxt;
      end
   end

   // Frame sequencing; a high chip select outside IDLE aborts straight back to IDLE
   always_comb begin
      state_nxt   = state;
      shreg_nxt   = shreg;
      bit_cnt_nxt = bit_cnt;
      case (state)
         IDLE: begin
            if (!bus.spi_cs) state_nxt = LOAD;
         end
         LOAD: begin
            shreg_nxt   = bus.spi_mosi_in;
            bit_cnt_nxt = '0;
            state_nxt   = SHIFT_LO;
         end
         SHIFT_LO: begin
            state_nxt = SHIFT_HI;
         end
         SHIFT_HI: begin
            if (bit_cnt == LAST_BIT) begin
               state_nxt = GAP;
            end else begin
               shreg_nxt   = shreg << 1;
               bit_cnt_nxt = bit_cnt + CW'(1);
               state_nxt   = SHIFT_LO;
            end
         end
         GAP: begin
            state_nxt = bus.spi_cs ? IDLE : LOAD;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      if (state != IDLE && bus.spi_cs) begin
         state_nxt   = IDLE;
         shreg_nxt   = shreg;
         bit_cnt_nxt = bit_cnt;
      end
   end

   // Pin outputs are decoded from registered state only, so they cannot glitch
   assign bus.control_clk  = (state == SHIFT_HI);
   assign bus.spi_mosi_out = (state == SHIFT_LO || state == SHIFT_HI) ? shreg[DATA_WIDTH-1] : 1'b0;
endmodule

// File: tb/tb_spi_mosi.sv
// tb/tb_spi_mosi.sv - self-checking bench for spi_mosi against a per-cycle waveform model
module tb_spi_mosi;
   localparam int W     = 8;
   localparam int FRAME = 2 * W + 2;

   logic spi_clk = 1'b0;
   logic n_reset;
   int   vectors     = 0;
   int   miscompares = 0;

   spi_mosi_if #(.DATA_WIDTH(W)) bus ();

   spi_mosi #(.DATA_WIDTH(W)) dut (
      .spi_clk (spi_clk),
      .n_reset (n_reset),
      .bus     (bus)
   );

   // System clock
   always #5 spi_clk = ~spi_clk;

   // Compare the pins on the falling edge, half a cycle away from the active edge
   task automatic check(input string tag, input logic exp_c, input logic exp_m);
      @(negedge spi_clk);
      vectors++;
      assert ({bus.control_clk, bus.spi_mosi_out} === {exp_c, exp_m}) else begin
         miscompares++;
         $error("FAIL %s: got ctrl=%b mosi=%b, expected ctrl=%b mosi=%b",
                tag, bus.control_clk, bus.spi_mosi_out, exp_c, exp_m);
      end
   endtask

   // One frame as seen on the pins: LOAD, then per bit MSB first a low and a high
   // serial-clock cycle carrying that bit, then one GAP cycle. Inputs are altered
   // after chosen samples: mid_k/mid_val, random noise during shifting, gap_val in
   // the GAP cycle, and stop_k ends the frame early by raising cs or reset.
   task automatic frame(input logic [W-1:0] d, input int mid_k, input logic [W-1:0] mid_val,
                        input logic [W-1:0] gap_val, input bit noise,
                        input int stop_k, input bit stop_rst);
      logic c, m;
      int   j;
      for (int k = 0; k < FRAME; k++) begin
         if (k == 0 || k == FRAME - 1) begin
            c = 1'b0;
            m = 1'b0;
         end else begin
            j = k - 1;
            c = (j % 2 == 1);
            m = d[W - 1 - j / 2];
         end
         check($sformatf("frame %02h k=%0d", d, k), c, m);
         if (noise && k >= 1 && k < FRAME - 1) bus.spi_mosi_in = W'($urandom);
         if (k == mid_k) bus.spi_mosi_in = mid_val;
         if (k == FRAME - 1) bus.spi_mosi_in = gap_val;
         if (k == stop_k) begin
            if (stop_rst) n_reset = 1'b1;
            else          bus.spi_cs = 1'b1;
            return;
         end
      end
   endtask

   initial begin
      logic [W-1:0] d, nxt;

      // Reset held two cycles with cs already low: nothing may toggle
      n_reset         = 1'b1;
      bus.spi_cs      = 1'b0;
      bus.spi_mosi_in = 8'hA5;
      check("reset cyc0", 1'b0, 1'b0);
      check("reset cyc1", 1'b0, 1'b0);
      n_reset = 1'b0;

      // Single frame, then back-to-back 47 -> 61 with the next byte set during GAP
      frame(8'hA5, -1, 8'h00, 8'h47, 1'b0, -1, 1'b0);
      frame(8'h47, -1, 8'h00, 8'h61, 1'b0, -1, 1'b0);
      frame(8'h61, -1, 8'h00, 8'h01, 1'b0, -1, 1'b0);

      // Input changed mid-shift must not disturb the frame in flight
      frame(8'h01, 7, 8'h02, 8'hFF, 1'b0, -1, 1'b0);

      // Chip-select abort after three bits, pins stay low, then a full fresh frame
      frame(8'hFF, -1, 8'h00, 8'hFF, 1'b0, 6, 1'b0);
      for (int i = 0; i < 4; i++) check($sformatf("abort idle %0d", i), 1'b0, 1'b0);
      bus.spi_cs = 1'b0;
      frame(8'hFF, -1, 8'h00, 8'h3C, 1'b0, -1, 1'b0);

      // Reset pulse after five bits, then a full frame of the current input
      frame(8'h3C, -1, 8'h00, 8'h3C, 1'b0, 10, 1'b1);
      check("reset mid-frame", 1'b0, 1'b0);
      n_reset = 1'b0;
      nxt = W'($urandom);
      frame(8'h3C, -1, 8'h00, nxt, 1'b0, -1, 1'b0);

      // Random back-to-back frames with the input churning while shifting
      for (int i = 0; i < 6; i++) begin
         d   = nxt;
         nxt = W'($urandom);
         frame(d, -1, 8'h00, nxt, 1'b1, -1, 1'b0);
      end

      // Release cs in the last GAP: the line returns to idle
      bus.spi_cs = 1'b1;
      for (int i = 0; i < 3; i++) check($sformatf("final idle %0d", i), 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
